dispatch_scheduler: RTL and testbench

In-order dispatch scheduler between the instruction buffer and the four functional-unit reservation stations (FXU0, FXU1, LSU, branch). It latches one 4-instruction bundle, steers each instruction to a unit by opcode class, round-robins ALU ops across the two FXUs, and respects per-unit full flags. While instructions wait, it snoops ROB result broadcasts to fill in operands. It requests the next bundle only once the current one has fully drained.

---
 rtl/dispatch_scheduler_if.sv | 67 ++++++
 rtl/dispatch_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_dispatch_scheduler.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_scheduler_if.sv
// Bundle-side, ROB-snoop and reservation-station ports of dispatch_scheduler.
// master = instruction buffer / ROB / unit side, slave = the scheduler.
interface dispatch_scheduler_if #(
  parameter int SLOTS = 4,
  parameter int DW    = 16,
  parameter int TW    = 4
);
  logic                      ib_valid;
  logic                      ib_ready;
  logic [SLOTS-1:0]          ib_slot_valid;
  logic [4*SLOTS-1:0]        ib_opcode;
  logic [SLOTS-1:0]          ib_a_valid;
  logic [SLOTS-1:0]          ib_b_valid;
  logic [DW*SLOTS-1:0]       ib_a_value;
  logic [DW*SLOTS-1:0]       ib_b_value;
  logic [TW*SLOTS-1:0]       ib_a_owner;
  logic [TW*SLOTS-1:0]       ib_b_owner;
  logic [TW*SLOTS-1:0]       ib_rt;
  logic [(2**TW)-1:0]        rob_output_valid;
  logic [DW*(2**TW)-1:0]     rob_output_values;
  logic                      fxu_0_full, fxu_1_full, lsu_full, branch_full;

  logic                      fxu0_valid, fxu1_valid, lsu_valid, br_valid;
  logic [3:0]                fxu0_opcode, fxu1_opcode, lsu_opcode, br_opcode;
  logic                      fxu0_a_valid, fxu1_a_valid, lsu_a_valid, br_a_valid;
  logic                      fxu0_b_valid, fxu1_b_valid, lsu_b_valid, br_b_valid;
  logic [DW-1:0]             fxu0_a_value, fxu1_a_value, lsu_a_value, br_a_value;
  logic [DW-1:0]             fxu0_b_value, fxu1_b_value, lsu_b_value, br_b_value;
  logic [TW-1:0]             fxu0_a_owner, fxu1_a_owner, lsu_a_owner, br_a_owner;
  logic [TW-1:0]             fxu0_b_owner, fxu1_b_owner, lsu_b_owner, br_b_owner;
  logic [TW-1:0]             fxu0_rt, fxu1_rt, lsu_rt, br_rt;
  logic [15:0]               stall_cycles;

  modport master (
    output ib_valid, ib_slot_valid, ib_opcode, ib_a_valid, ib_b_valid,
           ib_a_value, ib_b_value, ib_a_owner, ib_b_owner, ib_rt,
           rob_output_valid, rob_output_values,
           fxu_0_full, fxu_1_full, lsu_full, branch_full,
    input  ib_ready,
           fxu0_valid, fxu1_valid, lsu_valid, br_valid,
           fxu0_opcode, fxu1_opcode, lsu_opcode, br_opcode,
           fxu0_a_valid, fxu1_a_valid, lsu_a_valid, br_a_valid,
           fxu0_b_valid, fxu1_b_valid, lsu_b_valid, br_b_valid,
           fxu0_a_value, fxu1_a_value, lsu_a_value, br_a_value,
           fxu0_b_value, fxu1_b_value, lsu_b_value, br_b_value,
           fxu0_a_owner, fxu1_a_owner, lsu_a_owner, br_a_owner,
           fxu0_b_owner, fxu1_b_owner, lsu_b_owner, br_b_owner,
           fxu0_rt, fxu1_rt, lsu_rt, br_rt, stall_cycles
  );

  modport slave (
    input  ib_valid, ib_slot_valid, ib_opcode, ib_a_valid, ib_b_valid,
           ib_a_value, ib_b_value, ib_a_owner, ib_b_owner, ib_rt,
           rob_output_valid, rob_output_values,
           fxu_0_full, fxu_1_full, lsu_full, branch_full,
    output ib_ready,
           fxu0_valid, fxu1_valid, lsu_valid, br_valid,
           fxu0_opcode, fxu1_opcode, lsu_opcode, br_opcode,
           fxu0_a_valid, fxu1_a_valid, lsu_a_valid, br_a_valid,
           fxu0_b_valid, fxu1_b_valid, lsu_b_valid, br_b_valid,
           fxu0_a_value, fxu1_a_value, lsu_a_value, br_a_value,
           fxu0_b_value, fxu1_b_value, lsu_b_value, br_b_value,
           fxu0_a_owner, fxu1_a_owner, lsu_a_owner, br_a_owner,
           fxu0_b_owner, fxu1_b_owner, lsu_b_owner, br_b_owner,
           fxu0_rt, fxu1_rt, lsu_rt, br_rt, stall_cycles
  );
endinterface

// File: rtl/dispatch_scheduler.sv
// In-order 4-slot dispatch scheduler: steers one held bundle to FXU0/FXU1/LSU/branch.
// Define DISPATCH_SCHED_WAKEUP_EN to enable ROB result snoop and same-cycle operand bypass.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   S_EMPTY | no bundle held, ib_ready=1
//   S_HOLD  | bundle held, pending slots being dispatched in order
module dispatch_scheduler #(
  parameter int SLOTS = 4,
  parameter int DW    = 16,
  parameter int TW    = 4
) (
  input logic                clk,
  input logic                rst_n,
  dispatch_scheduler_if.slave bus
);
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int NU = 4;

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [SLOTS-1:0]  pend_q, pend_d, issue;
  logic [3:0]        op_q   [SLOTS];
  logic [SLOTS-1:0]  av_q, bv_q, av_e, bv_e;
  logic [DW-1:0]     aval_q [SLOTS];
  logic [DW-1:0]     bval_q [SLOTS];
  logic [DW-1:0]     aval_e [SLOTS];
  logic [DW-1:0]     bval_e [SLOTS];
  logic [TW-1:0]     aown_q [SLOTS];
  logic [TW-1:0]     bown_q [SLOTS];
  logic [TW-1:0]     rt_q   [SLOTS];
  logic              rr_q, rr_d;
  logic [15:0]       stall_q;

  logic [NU-1:0]     gnt;
  logic [SW-1:0]     gslot [NU];
  logic              blocked, fxu_any, first_fxu, pref, sel;
  logic [1:0]        fx_free;
  logic              accept;

  assign accept       = (state_q == S_EMPTY) && bus.ib_valid;
  assign bus.ib_ready = (state_q == S_EMPTY);

  // Effective operands: held copy, optionally overlaid with a ROB result this cycle
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      av_e[i]   = av_q[i];
      bv_e[i]   = bv_q[i];
      aval_e[i] = aval_q[i];
      bval_e[i] = bval_q[i];
`ifdef DISPATCH_SCHED_WAKEUP_EN
      if (!av_q[i] && bus.rob_output_valid[aown_q[i]]) begin
        av_e[i]   = 1'b1;
        aval_e[i] = bus.rob_output_values[int'(aown_q[i])*DW +: DW];
      end
      if (!bv_q[i] && bus.rob_output_valid[bown_q[i]]) begin
        bv_e[i]   = 1'b1;
        bval_e[i] = bus.rob_output_values[int'(bown_q[i])*DW +: DW];
      end
`endif
    end
  end

`ifndef DISPATCH_SCHED_WAKEUP_EN
  logic unused_rob;
  assign unused_rob = ^{bus.rob_output_valid, bus.rob_output_values};
`endif

  // In-order scan: units 0..3 = FXU0, FXU1, LSU, branch
  always_comb begin
    issue     = '0;
    gnt       = '0;
    for (int u = 0; u < NU; u++) gslot[u] = '0;
    rr_d      = rr_q;
    blocked   = 1'b0;
    fxu_any   = 1'b0;
    first_fxu = 1'b0;
    pref      = 1'b0;
    sel       = 1'b0;
    fx_free   = 2'b00;
    if (state_q == S_HOLD) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (pend_q[i] && !blocked) begin
          if (!op_q[i][3]) begin
            fx_free = {!gnt[1] && !bus.fxu_1_full, !gnt[0] && !bus.fxu_0_full};
            pref    = fxu_any ? !first_fxu : rr_q;
            if (fx_free[pref]) begin
              sel = pref;
            end else if (fx_free[!pref]) begin
              sel = !pref;
            end else begin
              blocked = 1'b1;
            end
            if (!blocked) begin
              if (sel) begin
                gnt[1]   = 1'b1;
                gslot[1] = SW'(i);
              end else begin
                gnt[0]   = 1'b1;
                gslot[0] = SW'(i);
              end
              if (!fxu_any) first_fxu = sel;
              fxu_any  = 1'b1;
              rr_d     = !sel;
              issue[i] = 1'b1;
            end
          end else if (op_q[i][3:1] == 3'b100) begin
            if (!gnt[2] && !bus.lsu_full) begin
              gnt[2]   = 1'b1;
              gslot[2] = SW'(i);
              issue[i] = 1'b1;
            end else begin
              blocked = 1'b1;
            end
          end else if (op_q[i] <= 4'hD) begin
            if (!gnt[3] && !bus.branch_full) begin
              gnt[3]   = 1'b1;
              gslot[3] = SW'(i);
              issue[i] = 1'b1;
            end else begin
              blocked = 1'b1;
            end
          end else begin
            issue[i] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      S_EMPTY: begin
        if (bus.ib_valid) begin
          pend_d = bus.ib_slot_valid;
          if (|bus.ib_slot_valid) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        pend_d = pend_q & ~issue;
        if (pend_d == '0) state_d = S_EMPTY;
      end
      default: begin
        state_d = S_EMPTY;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      pend_q  <= '0;
      rr_q    <= 1'b0;
      stall_q <= '0;
      av_q    <= '0;
      bv_q    <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        op_q[i]   <= '0;
        aval_q[i] <= '0;
        bval_q[i] <= '0;
        aown_q[i] <= '0;
        bown_q[i] <= '0;
        rt_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      if (state_q == S_HOLD && issue == '0 && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if (accept) begin
        av_q <= bus.ib_a_valid;
        bv_q <= bus.ib_b_valid;
        for (int i = 0; i < SLOTS; i++) begin
          op_q[i]   <= bus.ib_opcode[4*i +: 4];
          aval_q[i] <= bus.ib_a_value[DW*i +: DW];
          bval_q[i] <= bus.ib_b_value[DW*i +: DW];
          aown_q[i] <= bus.ib_a_owner[TW*i +: TW];
          bown_q[i] <= bus.ib_b_owner[TW*i +: TW];
          rt_q[i]   <= bus.ib_rt[TW*i +: TW];
        end
      end else if (state_q == S_HOLD) begin
        av_q <= av_e;
        bv_q <= bv_e;
        for (int i = 0; i < SLOTS; i++) begin
          aval_q[i] <= aval_e[i];
          bval_q[i] <= bval_e[i];
        end
      end
    end
  end

  assign bus.stall_cycles = stall_q;

  assign bus.fxu0_valid   = gnt[0];
  assign bus.fxu0_opcode  = op_q[gslot[0]];
  assign bus.fxu0_a_valid = av_e[gslot[0]];
  assign bus.fxu0_b_valid = bv_e[gslot[0]];
  assign bus.fxu0_a_value = aval_e[gslot[0]];
  assign bus.fxu0_b_value = bval_e[gslot[0]];
  assign bus.fxu0_a_owner = aown_q[gslot[0]];
  assign bus.fxu0_b_owner = bown_q[gslot[0]];
  assign bus.fxu0_rt      = rt_q[gslot[0]];

  assign bus.fxu1_valid   = gnt[1];
  assign bus.fxu1_opcode  = op_q[gslot[1]];
  assign bus.fxu1_a_valid = av_e[gslot[1]];
  assign bus.fxu1_b_valid = bv_e[gslot[1]];
  assign bus.fxu1_a_value = aval_e[gslot[1]];
  assign bus.fxu1_b_value = bval_e[gslot[1]];
  assign bus.fxu1_a_owner = aown_q[gslot[1]];
  assign bus.fxu1_b_owner = bown_q[gslot[1]];
  assign bus.fxu1_rt      = rt_q[gslot[1]];

  assign bus.lsu_valid    = gnt[2];
  assign bus.lsu_opcode   = op_q[gslot[2]];
  assign bus.lsu_a_valid  = av_e[gslot[2]];
  assign bus.lsu_b_valid  = bv_e[gslot[2]];
  assign bus.lsu_a_value  = aval_e[gslot[2]];
  assign bus.lsu_b_value  = bval_e[gslot[2]];
  assign bus.lsu_a_owner  = aown_q[gslot[2]];
  assign bus.lsu_b_owner  = bown_q[gslot[2]];
  assign bus.lsu_rt       = rt_q[gslot[2]];

  assign bus.br_valid     = gnt[3];
  assign bus.br_opcode    = op_q[gslot[3]];
  assign bus.br_a_valid   = av_e[gslot[3]];
  assign bus.br_b_valid   = bv_e[gslot[3]];
  assign bus.br_a_value   = aval_e[gslot[3]];
  assign bus.br_b_value   = bval_e[gslot[3]];
  assign bus.br_a_owner   = aown_q[gslot[3]];
  assign bus.br_b_owner   = bown_q[gslot[3]];
  assign bus.br_rt        = rt_q[gslot[3]];
endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler: steering, conflicts, in-order blocking,
// wakeup bypass, NOP retirement and asynchronous reset.
module tb_dispatch_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dispatch_scheduler_if #(.SLOTS(4), .DW(16), .TW(4)) ifc ();

  dispatch_scheduler #(.SLOTS(4), .DW(16), .TW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // slot i: rt = 8+i, a = 0x100+i, b = 0x200+i, owners a=i, b=4+i, operands valid
  task automatic offer(input logic [3:0] sv, input logic [15:0] ops);
    ifc.ib_valid      = 1'b1;
    ifc.ib_slot_valid = sv;
    ifc.ib_opcode     = ops;
    ifc.ib_a_valid    = 4'hF;
    ifc.ib_b_valid    = 4'hF;
    for (int i = 0; i < 4; i++) begin
      ifc.ib_rt[4*i +: 4]       = 4'(8 + i);
      ifc.ib_a_value[16*i +: 16] = 16'(16'h100 + i);
      ifc.ib_b_value[16*i +: 16] = 16'(16'h200 + i);
      ifc.ib_a_owner[4*i +: 4]  = 4'(i);
      ifc.ib_b_owner[4*i +: 4]  = 4'(4 + i);
    end
  endtask

  function automatic logic [3:0] strobes();
    return {ifc.br_valid, ifc.lsu_valid, ifc.fxu1_valid, ifc.fxu0_valid};
  endfunction

  initial begin
    rst_n                 = 1'b1;
    ifc.ib_valid          = 1'b0;
    ifc.ib_slot_valid     = '0;
    ifc.ib_opcode         = '0;
    ifc.ib_a_valid        = '0;
    ifc.ib_b_valid        = '0;
    ifc.ib_a_value        = '0;
    ifc.ib_b_value        = '0;
    ifc.ib_a_owner        = '0;
    ifc.ib_b_owner        = '0;
    ifc.ib_rt             = '0;
    ifc.rob_output_valid  = '0;
    ifc.rob_output_values = '0;
    ifc.fxu_0_full        = 1'b0;
    ifc.fxu_1_full        = 1'b0;
    ifc.lsu_full          = 1'b0;
    ifc.branch_full       = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(ifc.ib_ready), 32'd1);
    check("rst_stall", 32'(ifc.stall_cycles), 32'd0);
    check("rst_strobes", 32'(strobes()), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // full mix {1,8,A,2}, rr=0
    offer(4'hF, 16'h2A81);
    tick();
    ifc.ib_valid = 1'b0;
    check("mix_ready", 32'(ifc.ib_ready), 32'd0);
    check("mix_strobes", 32'(strobes()), 32'hF);
    check("mix_fxu0_rt", 32'(ifc.fxu0_rt), 32'd8);
    check("mix_lsu_rt", 32'(ifc.lsu_rt), 32'd9);
    check("mix_br_rt", 32'(ifc.br_rt), 32'd10);
    check("mix_fxu1_rt", 32'(ifc.fxu1_rt), 32'd11);
    check("mix_fxu1_op", 32'(ifc.fxu1_opcode), 32'h2);
    check("mix_br_op", 32'(ifc.br_opcode), 32'hA);
    check("mix_fxu0_a", 32'(ifc.fxu0_a_value), 32'h100);
    tick();
    check("mix_ready_after", 32'(ifc.ib_ready), 32'd1);
    check("mix_idle", 32'(strobes()), 32'd0);

    // conflict {1,1,1,8}, rr=0
    offer(4'hF, 16'h8111);
    tick();
    ifc.ib_valid = 1'b0;
    check("cf1_strobes", 32'(strobes()), 32'h3);
    check("cf1_fxu0_rt", 32'(ifc.fxu0_rt), 32'd8);
    check("cf1_fxu1_rt", 32'(ifc.fxu1_rt), 32'd9);
    tick();
    check("cf2_strobes", 32'(strobes()), 32'h5);
    check("cf2_fxu0_rt", 32'(ifc.fxu0_rt), 32'd10);
    check("cf2_lsu_rt", 32'(ifc.lsu_rt), 32'd11);
    check("cf2_ready", 32'(ifc.ib_ready), 32'd0);
    tick();
    check("cf_ready_after", 32'(ifc.ib_ready), 32'd1);

    // in-order block {8,1} with LSU full for 3 cycles; rr=1 now
    ifc.lsu_full = 1'b1;
    offer(4'h3, 16'h0018);
    tick();
    ifc.ib_valid = 1'b0;
    check("blk_c1", 32'(strobes()), 32'd0);
    tick();
    check("blk_c2", 32'(strobes()), 32'd0);
    tick();
    check("blk_c3", 32'(strobes()), 32'd0);
    tick();
    ifc.lsu_full = 1'b0;
    #1;
    check("blk_stall", 32'(ifc.stall_cycles), 32'd3);
    check("blk_c4", 32'(strobes()), 32'h6);
    check("blk_fxu1_rt", 32'(ifc.fxu1_rt), 32'd9);
    tick();
    check("blk_ready_after", 32'(ifc.ib_ready), 32'd1);
    check("blk_stall_hold", 32'(ifc.stall_cycles), 32'd3);

    // wakeup: slot0 op 3, a pending on tag 5; rr=0 now
    offer(4'h1, 16'h0003);
    ifc.ib_a_valid[0]      = 1'b0;
    ifc.ib_a_owner[3:0]    = 4'd5;
    ifc.ib_a_value[15:0]   = 16'hDEAD;
    tick();
    ifc.ib_valid = 1'b0;
    ifc.rob_output_valid[5]          = 1'b1;
    ifc.rob_output_values[5*16 +: 16] = 16'h1234;
    #1;
    check("wk_strobe", 32'(strobes()), 32'h1);
    check("wk_owner", 32'(ifc.fxu0_a_owner), 32'd5);
    check("wk_b_value", 32'(ifc.fxu0_b_value), 32'h200);
`ifdef DISPATCH_SCHED_WAKEUP_EN
    check("wk_a_valid", 32'(ifc.fxu0_a_valid), 32'd1);
    check("wk_a_value", 32'(ifc.fxu0_a_value), 32'h1234);
`else
    check("wk_a_valid", 32'(ifc.fxu0_a_valid), 32'd0);
    check("wk_a_value", 32'(ifc.fxu0_a_value), 32'hDEAD);
`endif
    tick();
    ifc.rob_output_valid = '0;
    ifc.rob_output_values = '0;

    // NOP bundle: retires in one cycle, no strobes, stall unchanged
    offer(4'hF, 16'hEEFE);
    tick();
    ifc.ib_valid = 1'b0;
    check("nop_strobes", 32'(strobes()), 32'd0);
    check("nop_ready", 32'(ifc.ib_ready), 32'd0);
    tick();
    check("nop_ready_after", 32'(ifc.ib_ready), 32'd1);
    check("nop_stall", 32'(ifc.stall_cycles), 32'd3);

    // empty bundle is swallowed, FSM stays EMPTY
    offer(4'h0, 16'h1111);
    tick();
    ifc.ib_valid = 1'b0;
    check("empty_ready", 32'(ifc.ib_ready), 32'd1);
    check("empty_strobes", 32'(strobes()), 32'd0);

    // rr=1 prefers FXU1, but it is full: falls back to FXU0
    ifc.fxu_1_full = 1'b1;
    offer(4'h1, 16'h0005);
    tick();
    ifc.ib_valid = 1'b0;
    check("steer_strobes", 32'(strobes()), 32'h1);
    check("steer_op", 32'(ifc.fxu0_opcode), 32'h5);
    tick();
    ifc.fxu_1_full = 1'b0;

    // reset mid-HOLD
    ifc.branch_full = 1'b1;
    offer(4'h1, 16'h000B);
    tick();
    ifc.ib_valid = 1'b0;
    check("hold_ready", 32'(ifc.ib_ready), 32'd0);
    tick();
    check("hold_stall", 32'(ifc.stall_cycles), 32'd4);
    ifc.branch_full = 1'b0;
    #1;
    check("hold_br_strobe", 32'(strobes()), 32'h8);
    #1 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ifc.ib_ready), 32'd1);
    check("arst_strobes", 32'(strobes()), 32'd0);
    check("arst_stall", 32'(ifc.stall_cycles), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_idle", 32'(strobes()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
